// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer states and default bus widths.
// Used by both the APB initiator and completer blocks.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Width needed to count 0..limit, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one initiator and one completer.
interface apb_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  prot;
  logic                  pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverror;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, prot, pstrb,
    input  prdata, pready, pslverror
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, prot, pstrb,
    output prdata, pready, pslverror
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait states and flags when the last permitted one is reached.
// With TIMEOUT = 0 no counter exists and the flag is never raised.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic ares,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = clr ^ en ^ ares;
      assign expired = 1'b0;
    end else begin : g_count
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0] count_reg;

      // Saturates at LAST; the FSM leaves ACCESS on that cycle anyway.
      always_ff @(posedge clock) begin
        if (ares) begin
          count_reg <= '0;
        end else if (clr) begin
          count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign expired = (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB initiator: converts valid/ready commands into SETUP/ACCESS transfers
// and reports each completion (or wait-state timeout) on a response strobe.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  ares,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_prot,
  input  logic                  cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  apb_master_if.master          apb
);

  apb_state_t state_reg;
  logic       accept;
  logic       wait_cycle;
  logic       expired;

  assign cmd_ready  = (state_reg == IDLE) && !ares;
  assign accept     = cmd_valid && cmd_ready;
  assign wait_cycle = (state_reg == ACCESS) && !apb.pready;

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .ares    (ares),
    .clr     (accept),
    .en      (wait_cycle),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (ares) begin
      state_reg   <= IDLE;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      apb.prot    <= 1'b0;
      apb.pstrb   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= SETUP;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            apb.pwrite  <= cmd_write;
            apb.paddr   <= cmd_addr;
            apb.pwdata  <= cmd_wdata;
            apb.prot    <= cmd_prot;
            apb.pstrb   <= cmd_strb;
          end
        end
        SETUP: begin
          state_reg   <= ACCESS;
          apb.penable <= 1'b1;
        end
        ACCESS: begin
          // pready wins over a timeout landing on the same cycle.
          if (apb.pready) begin
            state_reg   <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
            rsp_error   <= apb.pslverror;
            rsp_timeout <= 1'b0;
          end else if (expired) begin
            state_reg   <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
